// File: rtl/bbb_array_pkg.sv
// Shared types and constants for the BBB microphone-array scan sequencer.
package bbb_array_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RUN,
        DRAIN
    } scan_state_t;

    localparam int CALC_CYCLES = 9;
    localparam int STEP_MAX    = 7;
    localparam int CFG_W       = 8;

    typedef struct packed {
        logic [CFG_W-1:0] half_period;
        logic [CFG_W-1:0] sample_dly;
        logic             lr_sel;
    } scan_cfg_t;

endpackage

// File: rtl/bbb_array_step_calc.sv
// Iterative divide of the free half-period time by the column count, clamped.
module bbb_array_step_calc
    import bbb_array_pkg::*;
#(
    parameter int NUM_COLS = 8,
    parameter int AVAIL_W  = 9
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic signed [AVAIL_W-1:0] avail,
    output logic                      done,
    output logic [3:0]                q,
    output logic                      valid
);

    localparam logic signed [AVAIL_W-1:0] COLS = AVAIL_W'(NUM_COLS);
    localparam logic [3:0] Q_MAX  = 4'(STEP_MAX + 1);
    localparam logic [3:0] CNT_END = 4'(CALC_CYCLES - 1);

    logic signed [AVAIL_W-1:0] rem_q, rem_d;
    logic [3:0] q_q, q_d;
    logic [3:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;

    assign done  = busy_q && (cnt_q == CNT_END);
    assign q     = q_q;
    assign valid = (q_q != 4'd0);

    // One subtraction per cycle; eight steps cover the clamp at Q_MAX.
    always_comb begin
        rem_d  = rem_q;
        q_d    = q_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start) begin
            rem_d  = avail;
            q_d    = 4'd0;
            cnt_d  = 4'd0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (done) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 4'd1;
                if (rem_q >= COLS && q_q < Q_MAX) begin
                    rem_d = rem_q - COLS;
                    q_d   = q_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q  <= '0;
            q_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/bbb_array_scan_ctrl.sv
// PDM clock / sample-pulse sequencer with checked runtime configuration.
module bbb_array_scan_ctrl
    import bbb_array_pkg::*;
#(
    parameter int NUM_COLS  = 8,
    parameter int HP_WIDTH  = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [HP_WIDTH-1:0]  cfg_half_period,
    input  logic [HP_WIDTH-1:0]  cfg_sample_dly,
    input  logic                 cfg_lr_sel,
    output logic                 pdm_clk,
    output logic                 pulse_lr,
    output logic                 lr_sel,
    output logic [2:0]           cnt_step,
    output logic                 frame_strobe,
    output logic [CNT_WIDTH-1:0] period_cnt,
    output logic                 running,
    output logic                 cfg_err
);

    scan_state_t state_q, state_d;
    scan_cfg_t   shadow_q, shadow_d;

    logic [HP_WIDTH-1:0]  h_q, h_d;
    logic [HP_WIDTH-1:0]  d_q, d_d;
    logic [HP_WIDTH-1:0]  hp_cnt_q, hp_cnt_d;
    logic                 phase_q, phase_d;
    logic                 lr_sel_q, lr_sel_d;
    logic [2:0]           cnt_step_q, cnt_step_d;
    logic                 cfg_loaded_q, cfg_loaded_d;
    logic                 cfg_err_q, cfg_err_d;
    logic                 pdm_clk_q, pdm_clk_d;
    logic                 pulse_lr_q, pulse_lr_d;
    logic                 frame_strobe_q, frame_strobe_d;
    logic [CNT_WIDTH-1:0] period_cnt_q, period_cnt_d;

    logic                 handshake;
    logic signed [HP_WIDTH:0] avail;
    logic                 calc_done;
    logic [3:0]           calc_q;
    logic                 calc_valid;
    logic                 cfg_ok;
    logic [3:0]           q_m1;
    logic [HP_WIDTH-1:0]  h_last;
    logic                 wrap;
    logic [HP_WIDTH-1:0]  hp_nxt;
    logic                 ph_nxt;
    logic                 frame_nxt;

    assign cfg_ready = (state_q == IDLE);
    assign handshake = cfg_valid && cfg_ready;
    assign running   = (state_q == RUN) || (state_q == DRAIN);

    assign avail = $signed({1'b0, cfg_half_period})
                 - $signed({1'b0, cfg_sample_dly})
                 - $signed((HP_WIDTH+1)'(1));

    bbb_array_step_calc #(
        .NUM_COLS (NUM_COLS),
        .AVAIL_W  (HP_WIDTH + 1)
    ) u_step_calc (
        .clk   (clk),
        .reset (reset),
        .start (handshake),
        .avail (avail),
        .done  (calc_done),
        .q     (calc_q),
        .valid (calc_valid)
    );

    assign cfg_ok = calc_valid
                 && (shadow_q.half_period >= CFG_W'(2))
                 && (shadow_q.sample_dly < shadow_q.half_period);
    assign q_m1   = calc_q - 4'd1;

    // Position of the waveform in the next cycle; outputs register from it.
    assign h_last    = h_q - HP_WIDTH'(1);
    assign wrap      = (hp_cnt_q == h_last);
    assign hp_nxt    = wrap ? '0 : hp_cnt_q + HP_WIDTH'(1);
    assign ph_nxt    = wrap ? ~phase_q : phase_q;
    assign frame_nxt = !ph_nxt && (hp_nxt == h_last);

    always_comb begin
        state_d        = state_q;
        shadow_d       = shadow_q;
        h_d            = h_q;
        d_d            = d_q;
        hp_cnt_d       = hp_cnt_q;
        phase_d        = phase_q;
        lr_sel_d       = lr_sel_q;
        cnt_step_d     = cnt_step_q;
        cfg_loaded_d   = cfg_loaded_q;
        cfg_err_d      = cfg_err_q;
        pdm_clk_d      = 1'b0;
        pulse_lr_d     = 1'b0;
        frame_strobe_d = 1'b0;
        period_cnt_d   = period_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (handshake) begin
                    shadow_d.half_period = CFG_W'(cfg_half_period);
                    shadow_d.sample_dly  = CFG_W'(cfg_sample_dly);
                    shadow_d.lr_sel      = cfg_lr_sel;
                    state_d              = CALC;
                end else if (en && cfg_loaded_q) begin
                    state_d      = RUN;
                    hp_cnt_d     = '0;
                    phase_d      = 1'b1;
                    pdm_clk_d    = 1'b1;
                    pulse_lr_d   = (d_q == '0);
                    period_cnt_d = '0;
                end
            end
            CALC: begin
                if (calc_done) begin
                    state_d = IDLE;
                    if (cfg_ok) begin
                        h_d          = HP_WIDTH'(shadow_q.half_period);
                        d_d          = HP_WIDTH'(shadow_q.sample_dly);
                        lr_sel_d     = shadow_q.lr_sel;
                        cnt_step_d   = (q_m1 > 4'(STEP_MAX)) ? 3'(STEP_MAX)
                                                             : q_m1[2:0];
                        cfg_loaded_d = 1'b1;
                        cfg_err_d    = 1'b0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            RUN, DRAIN: begin
                // A drain ends only after a complete period has been emitted.
                if (state_q == DRAIN && frame_strobe_q) begin
                    state_d  = IDLE;
                    hp_cnt_d = '0;
                    phase_d  = 1'b0;
                end else begin
                    if (state_q == RUN && !en) begin
                        state_d = DRAIN;
                    end
                    hp_cnt_d       = hp_nxt;
                    phase_d        = ph_nxt;
                    pdm_clk_d      = ph_nxt;
                    pulse_lr_d     = (hp_nxt == d_q);
                    frame_strobe_d = frame_nxt;
                    if (frame_nxt) begin
                        period_cnt_d = period_cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            shadow_q       <= '0;
            h_q            <= '0;
            d_q            <= '0;
            hp_cnt_q       <= '0;
            phase_q        <= 1'b0;
            lr_sel_q       <= 1'b0;
            cnt_step_q     <= '0;
            cfg_loaded_q   <= 1'b0;
            cfg_err_q      <= 1'b0;
            pdm_clk_q      <= 1'b0;
            pulse_lr_q     <= 1'b0;
            frame_strobe_q <= 1'b0;
            period_cnt_q   <= '0;
        end else begin
            state_q        <= state_d;
            shadow_q       <= shadow_d;
            h_q            <= h_d;
            d_q            <= d_d;
            hp_cnt_q       <= hp_cnt_d;
            phase_q        <= phase_d;
            lr_sel_q       <= lr_sel_d;
            cnt_step_q     <= cnt_step_d;
            cfg_loaded_q   <= cfg_loaded_d;
            cfg_err_q      <= cfg_err_d;
            pdm_clk_q      <= pdm_clk_d;
            pulse_lr_q     <= pulse_lr_d;
            frame_strobe_q <= frame_strobe_d;
            period_cnt_q   <= period_cnt_d;
        end
    end

    assign pdm_clk      = pdm_clk_q;
    assign pulse_lr     = pulse_lr_q;
    assign lr_sel       = lr_sel_q;
    assign cnt_step     = cnt_step_q;
    assign frame_strobe = frame_strobe_q;
    assign period_cnt   = period_cnt_q;
    assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_bbb_array_scan_ctrl.sv
// Scoreboard bench: expected waveform events queued by stimulus, popped by a monitor.
module tb_bbb_array_scan_ctrl;

    localparam int CW    = 4;
    localparam int NCOLS = 8;
    localparam int K_START = 0;
    localparam int K_PULSE = 1;
    localparam int K_FRAME = 2;
    localparam int K_IDLE  = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [7:0]    cfg_half_period = '0;
    logic [7:0]    cfg_sample_dly = '0;
    logic          cfg_lr_sel = 1'b0;
    logic          pdm_clk;
    logic          pulse_lr;
    logic          lr_sel;
    logic [2:0]    cnt_step;
    logic          frame_strobe;
    logic [CW-1:0] period_cnt;
    logic          running;
    logic          cfg_err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit mon_en = 1'b1;
    logic prev_run = 1'b0;
    logic prev_rdy = 1'b1;

    typedef struct {
        int kind;
        int at;
        int val;
    } ev_t;
    ev_t exp_q[$];

    int m_loaded = 0;
    int m_h = 0;
    int m_d = 0;
    int m_lr = 0;
    int m_step = 0;
    int m_err = 0;

    bbb_array_scan_ctrl #(
        .NUM_COLS  (NCOLS),
        .HP_WIDTH  (8),
        .CNT_WIDTH (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .en              (en),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_half_period (cfg_half_period),
        .cfg_sample_dly  (cfg_sample_dly),
        .cfg_lr_sel      (cfg_lr_sel),
        .pdm_clk         (pdm_clk),
        .pulse_lr        (pulse_lr),
        .lr_sel          (lr_sel),
        .cnt_step        (cnt_step),
        .frame_strobe    (frame_strobe),
        .period_cnt      (period_cnt),
        .running         (running),
        .cfg_err         (cfg_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int idle_val(input int p, input int e, input int l, input int s);
        return (p << 5) | (e << 4) | (l << 3) | s;
    endfunction

    function automatic string kname(input int k);
        case (k)
            K_START: return "start";
            K_PULSE: return "pulse";
            K_FRAME: return "frame";
            default: return "idle";
        endcase
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic pop(input int kind, input int val);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_%s: got event at cyc %0d val %0d, want none",
                     kname(kind), cyc, val);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.at != cyc || e.val != val) begin
            bad++;
            $display("FAIL event_%s: got %s cyc %0d val %0d, want %s cyc %0d val %0d",
                     kname(e.kind), kname(kind), cyc, val, kname(e.kind), e.at, e.val);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (running && !prev_run) pop(K_START, int'(pdm_clk));
            if (pulse_lr) pop(K_PULSE, int'(pdm_clk));
            if (frame_strobe) pop(K_FRAME, int'(period_cnt));
            if (cfg_ready && !prev_rdy)
                pop(K_IDLE, idle_val(int'(pdm_clk), int'(cfg_err),
                                     int'(lr_sel), int'(cnt_step)));
        end
        prev_run <= running;
        prev_rdy <= cfg_ready;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input int at, input int val);
        ev_t e;
        e.kind = kind;
        e.at = at;
        e.val = val;
        exp_q.push_back(e);
    endtask

    // Called in an IDLE cycle; the handshake completes this cycle.
    task automatic do_cfg(input int h, input int d, input int lr);
        int t, avail, q;
        t = cyc;
        cfg_half_period = 8'(h);
        cfg_sample_dly = 8'(d);
        cfg_lr_sel = lr[0];
        cfg_valid = 1'b1;
        avail = h - d - 1;
        q = (avail >= NCOLS) ? avail / NCOLS : 0;
        if (q > 8) q = 8;
        if (h >= 2 && d < h && q >= 1) begin
            m_loaded = 1;
            m_h = h;
            m_d = d;
            m_lr = lr;
            m_step = (q - 1 > 7) ? 7 : q - 1;
            m_err = 0;
        end else begin
            m_err = 1;
        end
        push(K_IDLE, t + 10, idle_val(0, m_err, m_lr, m_step));
        tick();
        cfg_valid = 1'b0;
        while (cyc < t + 10) tick();
    endtask

    // en held for len cycles from an IDLE cycle; optional re-assert in drain.
    task automatic run_once(input int len, input bit reassert);
        int s, k, f, per, b;
        s = cyc + 1;
        k = cyc + len;
        per = 2 * m_h;
        f = s + per - 1;
        while (f <= k) f += per;
        push(K_START, s, 1);
        for (int p = 0; s + p * per <= f; p++) begin
            b = s + p * per;
            push(K_PULSE, b + m_d, 1);
            push(K_PULSE, b + m_h + m_d, 0);
            push(K_FRAME, b + per - 1, (p + 1) % (1 << CW));
        end
        push(K_IDLE, f + 1, idle_val(0, m_err, m_lr, m_step));
        en = 1'b1;
        while (cyc < k) tick();
        en = 1'b0;
        if (reassert) begin
            tick();
            en = 1'b1;
        end
        while (cyc < f + 1) tick();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h, d, lr;
        bit ra;
        int s0;
        #1 reset = 1'b1;
        tick();
        tick();
        check("rst_cfg_ready", int'(cfg_ready), 1);
        check("rst_outs", int'({pdm_clk, pulse_lr, lr_sel, cnt_step, frame_strobe,
                                period_cnt, cfg_err, running}), 0);
        reset = 1'b0;
        tick();

        en = 1'b1;
        repeat (15) tick();
        check("noload_running", int'(running), 0);
        check("noload_pdm", int'(pdm_clk), 0);
        en = 1'b0;
        tick();

        do_cfg(20, 20, 1);
        check("dh_eq_err", int'(cfg_err), 1);
        en = 1'b1;
        repeat (15) tick();
        check("rejected_idle", int'(running), 0);
        en = 1'b0;
        tick();

        do_cfg(40, 4, 1);
        check("h40_step", int'(cnt_step), 3);
        run_once(100, 1'b1);
        run_once(100, 1'b0);

        do_cfg(10, 4, 0);
        check("h10_err", int'(cfg_err), 1);
        check("h10_keep_step", int'(cnt_step), 3);
        do_cfg(200, 0, 0);
        check("h200_err", int'(cfg_err), 0);
        check("h200_step", int'(cnt_step), 7);
        run_once(10, 1'b0);

        for (int i = 0; i < 14; i++) begin
            h = $urandom_range(60, 2);
            d = $urandom_range(h, 0);
            lr = $urandom_range(1, 0);
            do_cfg(h, d, lr);
            if (m_loaded != 0) begin
                ra = 1'($urandom_range(1, 0));
                run_once($urandom_range(5 * m_h, 1), ra);
                if (ra) run_once($urandom_range(3 * m_h, 1), 1'b0);
            end
        end

        do_cfg(9, 0, 1);
        check("h9_step", int'(cnt_step), 0);
        run_once(17 * 18, 1'b0);

        tick();
        check("queue_empty", exp_q.size(), 0);

        do_cfg(12, 2, 1);
        mon_en = 1'b0;
        en = 1'b1;
        tick();
        s0 = cyc;
        while (cyc < s0 + 2) tick();
        @(negedge clk);
        check("pre_rst_pulse", int'(pulse_lr), 1);
        check("pre_rst_pdm", int'(pdm_clk), 1);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_pulse", int'(pulse_lr), 0);
        check("mid_rst_pdm", int'(pdm_clk), 0);
        check("mid_rst_running", int'(running), 0);
        check("mid_rst_ready", int'(cfg_ready), 1);
        en = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
